// File: rtl/v_hier_qmon.sv
// v_hier_qmon: change monitor for the 4-bit qvec bus coming from v_hier_sub.
//
// qvec is sampled on every rising clock edge. When a sample differs from the
// one before it, an {old, new} record is pushed into a small first-word-fall-
// through FIFO. The consumer drains that FIFO with a valid/ready handshake.
// A saturating change counter and a sticky overflow flag are kept for debug.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   monitor enable; when low, sampling stops and the monitor re-primes
//   clr        in   synchronous clear of chg_count and overflow
//   qvec       in   [3:0] monitored bus
//   rec_valid  out  FIFO holds at least one record
//   rec_ready  in   consumer takes the head record this cycle
//   rec_data   out  [7:0] head record {old_qvec, new_qvec}
//   fifo_level out  [$clog2(DEPTH):0] number of records held
//   chg_count  out  [CNTW-1:0] saturating count of detected changes
//   overflow   out  sticky: a record was dropped because the FIFO was full
module v_hier_qmon #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clr,
    input  logic [3:0]             qvec,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [7:0]             rec_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNTW-1:0]        chg_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {UNPRIMED, ARMED} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      q_prev_reg;
    logic [7:0]      mem [DEPTH];
    logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] cnt_reg;
    logic            ovf_reg;

    logic change, full, pop, do_write, drop;

    // Next-state and change detection. Only an ARMED monitor can see a
    // change, so the first sample after reset or re-enable never produces one.
    always_comb begin
        state_next = state_reg;
        change     = 1'b0;
        if (!enable) begin
            state_next = UNPRIMED;
        end else begin
            state_next = ARMED;
            change     = (state_reg == ARMED) && (qvec != q_prev_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= UNPRIMED;
            q_prev_reg <= 4'h0;
        end else begin
            state_reg <= state_next;
            if (enable)
                q_prev_reg <= qvec;
        end
    end

    // Pointers carry one extra bit so that full (level == DEPTH) and empty
    // (level == 0) are distinguishable; their difference is the level.
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign full       = (fifo_level == FULL_LEVEL);
    assign rec_valid  = (fifo_level != '0);
    assign pop        = rec_valid & rec_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // only fails when nothing leaves.
    assign do_write   = change & (~full | pop);
    assign drop       = change & full & ~pop;

    // Storage is not reset; rec_data is forced to zero while empty so no
    // stale entry is ever presented.
    assign rec_data = rec_valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr_reg[AW-1:0]] <= {q_prev_reg, qvec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_write)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Dropped records still count. clr beats an increment, but a drop in the
    // clr cycle still raises overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (clr)
                cnt_reg <= '0;
            else if (change && (cnt_reg != {CNTW{1'b1}}))
                cnt_reg <= cnt_reg + 1'b1;

            if (drop)
                ovf_reg <= 1'b1;
            else if (clr)
                ovf_reg <= 1'b0;
        end
    end

    assign chg_count = cnt_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_v_hier_qmon.sv
// Bench for v_hier_qmon: directed scenarios plus a randomized run, all
// compared against a queue-based model of the monitor.
module tb_v_hier_qmon;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clr = 1'b0;
    logic       rec_ready = 1'b0;
    logic [3:0] qvec = 4'h0;
    logic       rec_valid;
    logic [7:0] rec_data;
    logic [2:0] fifo_level;
    logic [7:0] chg_count;
    logic       overflow;

    // Second instance with a 2-bit counter for the saturation scenario.
    logic       sat_en = 1'b0;
    logic [3:0] sat_q = 4'h0;
    logic       sat_valid;
    logic [7:0] sat_data;
    logic [2:0] sat_level;
    logic [1:0] sat_count;
    logic       sat_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    v_hier_qmon #(.DEPTH(DEPTH), .CNTW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .qvec(qvec),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .fifo_level(fifo_level), .chg_count(chg_count), .overflow(overflow)
    );

    v_hier_qmon #(.DEPTH(DEPTH), .CNTW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(sat_en), .clr(1'b0), .qvec(sat_q),
        .rec_valid(sat_valid), .rec_ready(1'b1), .rec_data(sat_data),
        .fifo_level(sat_level), .chg_count(sat_count), .overflow(sat_ovf)
    );

    // ---------------- reference model ----------------
    byte unsigned exp_q[$];
    int           exp_cnt;
    bit           exp_ovf;
    bit           m_primed;
    logic [3:0]   m_prev;

    task automatic model_reset();
        exp_q.delete();
        exp_cnt  = 0;
        exp_ovf  = 1'b0;
        m_primed = 1'b0;
        m_prev   = 4'h0;
    endtask

    // Applies one rising edge to the model using the inputs held before it.
    task automatic model_edge();
        int sz;
        bit pop, chg, drop;
        sz   = exp_q.size();
        pop  = (sz > 0) && rec_ready;
        chg  = enable && m_primed && (qvec != m_prev);
        drop = chg && (sz == DEPTH) && !pop;
        if (pop) void'(exp_q.pop_front());
        if (chg && !drop) exp_q.push_back({m_prev, qvec});
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        if (clr) exp_cnt = 0;
        else if (chg && exp_cnt < 255) exp_cnt++;
        m_primed = enable;
        if (enable) m_prev = qvec;
    endtask

    function automatic logic [20:0] exp_view();
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        return {exp_q.size() != 0, head, 3'(exp_q.size()), 8'(exp_cnt), exp_ovf};
    endfunction

    function automatic logic [20:0] act_view();
        return {rec_valid, rec_valid ? rec_data : 8'h00, fifo_level, chg_count, overflow};
    endfunction

    // One clock: model follows the edge, control returns at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_checks++;
        if ({rec_valid, rec_data, fifo_level, chg_count, overflow} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required 000000", {rec_valid, rec_data, fifo_level, chg_count, overflow});
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        qvec   = 4'h5;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (rec_valid !== 1'b0 || chg_count !== 8'd0) begin
                n_fail++;
                $display("FAIL prime_no_record: cycle %0d valid %b count %0d required 0 0", i, rec_valid, chg_count);
            end
        end
    endtask

    task automatic test_single_change();
        qvec = 4'hA;
        cyc();
        n_checks++;
        if ({rec_valid, rec_data, fifo_level, chg_count} !== {1'b1, 8'h5A, 3'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL single_change: got v=%b d=%h l=%0d c=%0d required v=1 d=5a l=1 c=1", rec_valid, rec_data, fifo_level, chg_count);
        end
        rec_ready = 1'b1;
        cyc();
        rec_ready = 1'b0;
        n_checks++;
        if (act_view() !== exp_view()) begin
            n_fail++;
            $display("FAIL single_drain: got %h required %h", act_view(), exp_view());
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_list [4];
        exp_list = '{8'h01, 8'h12, 8'h23, 8'h34};
        enable = 1'b0;
        clr    = 1'b1;
        cyc();
        clr    = 1'b0;
        enable = 1'b1;
        qvec   = 4'h0;
        cyc();
        for (int v = 1; v <= 5; v++) begin
            qvec = 4'(v);
            cyc();
            n_checks++;
            if (act_view() !== exp_view()) begin
                n_fail++;
                $display("FAIL fill_step%0d: got %h required %h", v, act_view(), exp_view());
            end
        end
        n_checks++;
        if ({fifo_level, overflow, chg_count, rec_data} !== {3'd4, 1'b1, 8'd5, 8'h01}) begin
            n_fail++;
            $display("FAIL overflow_state: got l=%0d o=%b c=%0d d=%h required l=4 o=1 c=5 d=01", fifo_level, overflow, chg_count, rec_data);
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rec_valid !== 1'b1 || rec_data !== exp_list[i]) begin
                n_fail++;
                $display("FAIL drain_order%0d: got v=%b d=%h required v=1 d=%h", i, rec_valid, rec_data, exp_list[i]);
            end
            cyc();
        end
        rec_ready = 1'b0;
        n_checks++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got valid %b required 0", rec_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_list [4];
        exp_list = '{8'h67, 8'h78, 8'h89, 8'h9A};
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int v = 6; v <= 9; v++) begin
            qvec = 4'(v);
            cyc();
        end
        n_checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_setup: got l=%0d o=%b required l=4 o=0", fifo_level, overflow);
        end
        qvec      = 4'hA;
        rec_ready = 1'b1;
        cyc();
        rec_ready = 1'b0;
        n_checks++;
        if ({fifo_level, overflow, rec_data} !== {3'd4, 1'b0, 8'h67}) begin
            n_fail++;
            $display("FAIL full_push_pop: got l=%0d o=%b d=%h required l=4 o=0 d=67", fifo_level, overflow, rec_data);
        end
        n_checks++;
        if (act_view() !== exp_view()) begin
            n_fail++;
            $display("FAIL full_push_pop_model: got %h required %h", act_view(), exp_view());
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rec_data !== exp_list[i]) begin
                n_fail++;
                $display("FAIL full_drain%0d: got %h required %h", i, rec_data, exp_list[i]);
            end
            cyc();
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_enable_gap_clr();
        qvec = 4'h3;
        cyc();
        rec_ready = 1'b1;
        cyc();
        rec_ready = 1'b0;
        enable = 1'b0;
        cyc();
        qvec = 4'h9;
        cyc();
        cyc();
        enable = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (rec_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL enable_gap: got v=%b l=%0d required v=0 l=0", rec_valid, fifo_level);
        end
        qvec = 4'h4;
        clr  = 1'b1;
        cyc();
        clr  = 1'b0;
        n_checks++;
        if ({chg_count, rec_valid, rec_data} !== {8'd0, 1'b1, 8'h94}) begin
            n_fail++;
            $display("FAIL clr_with_change: got c=%0d v=%b d=%h required c=0 v=1 d=94", chg_count, rec_valid, rec_data);
        end
        rec_ready = 1'b1;
        cyc();
        rec_ready = 1'b0;
    endtask

    task automatic test_saturation();
        byte unsigned got[$];
        logic [7:0] exp_list [5];
        exp_list = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45};
        sat_en = 1'b1;
        sat_q  = 4'h0;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            if (i <= 5) sat_q = 4'(i);
            cyc();
            if (sat_valid) got.push_back(sat_data);
        end
        sat_en = 1'b0;
        n_checks++;
        if (sat_count !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_count: got %0d required 3", sat_count);
        end
        n_checks++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL sat_records: got %0d records required 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_list[i]) begin
                n_fail++;
                $display("FAIL sat_rec%0d: got %h required %h", i, got[i], exp_list[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            clr       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) != 0) qvec = 4'($urandom_range(0, 15));
            rec_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc();
            n_checks++;
            if (act_view() !== exp_view()) begin
                n_fail++;
                $display("FAIL random%0d: got %h required %h", i, act_view(), exp_view());
            end
        end
        enable    = 1'b1;
        clr       = 1'b0;
        rec_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int v = 1; v <= 3; v++) begin
            qvec = qvec + 4'(v);
            cyc();
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rec_valid, rec_data, fifo_level, chg_count, overflow} !== 21'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required 000000", {rec_valid, rec_data, fifo_level, chg_count, overflow});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        qvec  = qvec + 4'h1;
        cyc();
        n_checks++;
        if (act_view() !== exp_view() || rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reprime_after_reset: got %h required %h", act_view(), exp_view());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_change();
        test_fill_overflow();
        test_full_push_pop();
        test_enable_gap_clr();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
